// File: rtl/weig_pkg.sv
// weig_pkg: shared constants, FSM states and first address for the layer-1 weight memory
package weig_pkg;
  localparam int DW = 16;
  localparam int N_BYTE = 784;
  localparam int N_IMG = 200;
  localparam int BYTE_AW = 10;
  localparam int IMG_AW = 8;
  localparam int FLAT_AW = 18;
  localparam int FIRST_ADDR = 1;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
endpackage

// File: rtl/weig_addr_gen.sv
// weig_addr_gen: 1-based byte/img/flat write counters with load, advance and last-address flag
module weig_addr_gen
  import weig_pkg::*;
#(
  parameter int NB = N_BYTE,
  parameter int NI = N_IMG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               adv,
  output logic [BYTE_AW-1:0] byte_cnt,
  output logic [IMG_AW-1:0]  img_cnt,
  output logic [FLAT_AW-1:0] flat_cnt,
  output logic               last
);
  logic byte_wrap;
  assign byte_wrap = byte_cnt == BYTE_AW'(NB);
  assign last = byte_wrap && img_cnt == IMG_AW'(NI);
  // flat runs alongside byte/img so no (img-1)*NB multiply is needed
  always_ff @(posedge clk) begin
    if (rst || load) begin
      byte_cnt <= BYTE_AW'(FIRST_ADDR);
      img_cnt  <= IMG_AW'(FIRST_ADDR);
      flat_cnt <= FLAT_AW'(FIRST_ADDR);
    end else if (adv) begin
      byte_cnt <= byte_wrap ? BYTE_AW'(FIRST_ADDR) : byte_cnt + 1'b1;
      img_cnt  <= byte_wrap ? img_cnt + 1'b1 : img_cnt;
      flat_cnt <= flat_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sram_weig1_writer.sv
// sram_weig1_writer: streams weights into the layer-1 weight memory with (img,byte,flat) addressing
// Optional running checksum output enabled by SRAM_WEIG1_CHECKSUM_EN.
module sram_weig1_writer
  import weig_pkg::*;
#(
  parameter int NB = N_BYTE,
  parameter int NI = N_IMG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_valid,
  input  logic [DW-1:0]      s_data,
  output logic               s_ready,
  output logic               wr_en,
  output logic [BYTE_AW-1:0] wr_addr_byte,
  output logic [IMG_AW-1:0]  wr_addr_img,
  output logic [FLAT_AW-1:0] wr_addr_flat,
  output logic [DW-1:0]      wr_data,
  output logic               busy,
  output logic               done
`ifdef SRAM_WEIG1_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);
  state_t state;
  logic xfer, load, last;
  logic [BYTE_AW-1:0] byte_cnt;
  logic [IMG_AW-1:0] img_cnt;
  logic [FLAT_AW-1:0] flat_cnt;
  assign s_ready = state == LOAD;
  assign busy = state == LOAD;
  assign done = state == DONE;
  assign xfer = s_valid && s_ready;
  assign load = start && state != LOAD;
  weig_addr_gen #(.NB(NB), .NI(NI)) u_addr (
    .clk(clk), .rst(rst), .load(load), .adv(xfer),
    .byte_cnt(byte_cnt), .img_cnt(img_cnt), .flat_cnt(flat_cnt), .last(last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_en        <= 1'b0;
      wr_data      <= '0;
      wr_addr_byte <= '0;
      wr_addr_img  <= '0;
      wr_addr_flat <= '0;
    end else begin
      wr_en <= xfer;
      if (xfer) begin
        wr_data      <= s_data;
        wr_addr_byte <= byte_cnt;
        wr_addr_img  <= img_cnt;
        wr_addr_flat <= flat_cnt;
      end
      if (load) state <= LOAD;
      else if (xfer && last) state <= DONE;
    end
  end
`ifdef SRAM_WEIG1_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || load) checksum <= '0;
    else if (xfer) checksum <= checksum + 32'(s_data);
  end
`endif
endmodule

// File: doc/sram_weig1_writer.md
Name: sram_weig1_writer

Overview:
- Write-side controller for the layer-1 weight memory. It accepts a serial stream of 16-bit fixed-point weights over a valid/ready handshake and generates the 1-based (img, byte) addresses and a flat address matching the read-side layout: flat = (img-1)*N_BYTE + byte.
- It replaces the file preload, so weights can be reloaded at run time.
- While loading it asserts busy, so the accelerator controller holds its read enable low.

Parameters:
- DW, 16, weight word width.
- N_BYTE, 784, words per image row (byte address range 1..N_BYTE).
- N_IMG, 200, rows (img address range 1..N_IMG).
- BYTE_AW, 10, byte address width.
- IMG_AW, 8, img address width.
- FLAT_AW, 18, flat address width; must cover N_BYTE*N_IMG = 156800.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load from address (1,1).
- s_valid  in  1  input word valid.
- s_data  in  DW  input weight word.
- s_ready  out  1  writer can accept a word.
- wr_en  out  1  memory write strobe, one cycle per word.
- wr_addr_byte  out  BYTE_AW  byte address, 1..N_BYTE.
- wr_addr_img  out  IMG_AW  img address, 1..N_IMG.
- wr_addr_flat  out  FLAT_AW  flat address, 1..N_BYTE*N_IMG.
- wr_data  out  DW  data written.
- busy  out  1  high in state LOAD.
- done  out  1  high in state DONE.

Behaviour:
- Reset values:
  - state = IDLE.
  - s_ready = 0, wr_en = 0, busy = 0, done = 0.
  - wr_data = 0; all addresses = 0.
  - Internal counters: byte = 1, img = 1, flat = 1.
- FSM states: IDLE, LOAD, DONE.
  - IDLE to LOAD on start.
  - DONE to LOAD on start; entering LOAD clears done.
  - LOAD to DONE on the transfer of the last word (byte = N_BYTE and img = N_IMG).
  - start during LOAD is ignored; counters are not reset.
- On entering LOAD, counters are loaded to (1,1,1).
- s_ready is combinational: high exactly when state = LOAD.
- A transfer occurs when s_valid and s_ready are both high in the same cycle.
- Transfer timing (latency 1 cycle):
  - On the next posedge, wr_en = 1 and wr_data = s_data.
  - The address outputs take the pre-increment counter values.
  - In the same cycle the counters advance.
  - wr_en = 0 in any cycle that follows a cycle with no transfer.
- Counter advance:
  - byte increments each transfer.
  - When byte = N_BYTE it wraps to 1 and img increments.
  - flat increments every transfer. It is computed incrementally; no multiplier.
- Back-to-back transfers are sustained at 1 word per cycle. s_valid gaps only insert wr_en = 0 cycles.
- Last word: the final wr_en is written at (N_BYTE, N_IMG, 156800).
  - In the same cycle state = DONE, so done = 1, busy = 0, s_ready = 0.
  - s_valid arriving in DONE or IDLE is not accepted and produces no write.
- Outputs hold their last values when wr_en = 0; only wr_en qualifies them.
- rst during LOAD aborts the load: all outputs go to their reset values on the next edge, and a partial image is left in memory.
- start coincident with rst: rst wins.

Optional Feature:
- Macro: SRAM_WEIG1_CHECKSUM_EN.
- When defined:
  - Adds output checksum (32 bits), which is the running unsigned 32-bit wrap-around sum of every transferred s_data.
  - checksum is cleared on entering LOAD and updated in the same cycle wr_en is driven.
  - checksum is valid while done = 1.
  - Reset value is 0.
- When undefined: no port and no logic; all other behaviour is identical.

Decomposition:
- Shared package weig_pkg contains:
  - constants N_BYTE, N_IMG, DW and the address widths;
  - the FSM state enum (IDLE, LOAD, DONE);
  - the first-address constant 1.
- Read and write sides both import weig_pkg.
- One sub-module, weig_addr_gen, holds the byte/img/flat counters. It has load and advance inputs, and an output that flags the last address.

Test Plan:
- Reset, then start, then 784*200 words driven back to back with s_data = index mod 65536. Required:
  - 156800 wr_en pulses, with wr_addr_flat running 1..156800 with no gaps;
  - done = 1 in the cycle after the last transfer.
- Word 784 lands at (784,1,784). Word 785 lands at (1,2,785).
- s_valid toggled every other cycle: wr_en follows one cycle later with the same gaps; the address sequence is unchanged; busy stays 1.
- start pulsed at word 500: ignored. The next write is at flat 501.
- rst asserted at word 1000:
  - next cycle, all outputs are 0 and state = IDLE;
  - a subsequent start restarts at (1,1,1).
- After DONE, hold s_valid = 1 for 10 cycles: no wr_en and s_ready = 0. Then start: done drops and a write lands at (1,1,1).
- With SRAM_WEIG1_CHECKSUM_EN: 156800 words of 0x0001 give checksum = 156800. Words of 0xFFFF give 156800*65535 mod 2^32.
